// File: rtl/pad_input_filter.sv
// Pad input conditioner: synchronizer chain, debounce FSM, edge pulses and optional rise counter.
// Defining PAD_INPUT_FILTER_EVT_CNT_EN builds the rising-edge event counter.
module pad_input_filter #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic        RST_VAL         = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pad_i,
   input  logic        en_i,
   input  logic        clr_i,
   output logic        filt_o,
   output logic        rise_o,
   output logic        fall_o,
   output logic [15:0] evt_cnt_o
);

   localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StStableLo = 2'd0,
      StPendHi   = 2'd1,
      StStableHi = 2'd2,
      StPendLo   = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_e                 state_q, state_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en_i) begin
         // Disabled: drop any pending change and hold the committed level.
         cnt_d = 16'd0;
         if (state_q == StPendHi) state_d = StStableLo;
         if (state_q == StPendLo) state_d = StStableHi;
      end else begin
         unique case (state_q)
            StStableLo: begin
               if (s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_d = StStableHi;
                  end else begin
                     state_d = StPendHi;
                     cnt_d   = 16'd1;
                  end
               end
            end
            StPendHi: begin
               if (!s) begin
                  state_d = StStableLo;
                  cnt_d   = 16'd0;
               end else if (cnt_q == CntLast) begin
                  state_d = StStableHi;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            StStableHi: begin
               if (!s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_d = StStableLo;
                  end else begin
                     state_d = StPendLo;
                     cnt_d   = 16'd1;
                  end
               end
            end
            StPendLo: begin
               if (s) begin
                  state_d = StStableHi;
                  cnt_d   = 16'd0;
               end else if (cnt_q == CntLast) begin
                  state_d = StStableLo;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: begin
               state_d = StStableLo;
               cnt_d   = 16'd0;
            end
         endcase
      end
      filt_d = (state_d == StStableHi) || (state_d == StPendLo);
      rise_d = (state_d == StStableHi) && ((state_q == StStableLo) || (state_q == StPendHi));
      fall_d = (state_d == StStableLo) && ((state_q == StStableHi) || (state_q == StPendLo));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= RST_VAL ? StStableHi : StStableLo;
         cnt_q   <= 16'd0;
         filt_q  <= RST_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign filt_o = filt_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef PAD_INPUT_FILTER_EVT_CNT_EN
   logic [15:0] evt_cnt_q;

   // Clear takes priority over a coincident rise pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         evt_cnt_q <= 16'd0;
      end else if (clr_i) begin
         evt_cnt_q <= 16'd0;
      end else if (rise_q && (evt_cnt_q != 16'hFFFF)) begin
         evt_cnt_q <= evt_cnt_q + 16'd1;
      end
   end

   assign evt_cnt_o = evt_cnt_q;
`else
   logic unused_clr;
   assign unused_clr = clr_i;
   assign evt_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// Bench for pad_input_filter: two configurations checked every cycle against a run-length model,
// plus directed latency, glitch, enable, reset and counter scenarios.
module tb_pad_input_filter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pad;
   logic        en;
   logic        clr;
   logic        filt [2];
   logic        rise [2];
   logic        fall [2];
   logic [15:0] evt  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pad_input_filter #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RST_VAL(1'b0)
   ) u_slow (
      .clk_i(clk), .rst_ni(rst_n), .pad_i(pad), .en_i(en), .clr_i(clr),
      .filt_o(filt[0]), .rise_o(rise[0]), .fall_o(fall[0]), .evt_cnt_o(evt[0])
   );

   pad_input_filter #(
      .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RST_VAL(1'b1)
   ) u_fast (
      .clk_i(clk), .rst_ni(rst_n), .pad_i(pad), .en_i(en), .clr_i(clr),
      .filt_o(filt[1]), .rise_o(rise[1]), .fall_o(fall[1]), .evt_cnt_o(evt[1])
   );

   // Reference model: committed level flips after D consecutive enabled samples that differ.
   int          m_sync [2] = '{2, 3};
   int          m_deb  [2] = '{4, 1};
   logic        m_rst  [2] = '{1'b0, 1'b1};
   logic [3:0]  hist   [2];
   logic        lvl    [2];
   int          run    [2];
   logic        erise  [2];
   logic        efall  [2];
   logic [15:0] ecnt   [2];
`ifdef PAD_INPUT_FILTER_EVT_CNT_EN
   bit          cnt_built = 1'b1;
`else
   bit          cnt_built = 1'b0;
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_edge(input int i);
      logic s;
      logic prev_rise;
      prev_rise = erise[i];
      if (!rst_n) begin
         hist[i]  = {4{m_rst[i]}};
         lvl[i]   = m_rst[i];
         run[i]   = 0;
         erise[i] = 1'b0;
         efall[i] = 1'b0;
         ecnt[i]  = 16'd0;
         return;
      end
      s        = hist[i][m_sync[i]-1];
      hist[i]  = {hist[i][2:0], pad};
      erise[i] = 1'b0;
      efall[i] = 1'b0;
      if (en && (s != lvl[i])) begin
         run[i]++;
         if (run[i] == m_deb[i]) begin
            lvl[i]   = s;
            run[i]   = 0;
            erise[i] = s;
            efall[i] = !s;
         end
      end else begin
         run[i] = 0;
      end
      if (cnt_built) begin
         if (clr) ecnt[i] = 16'd0;
         else if (prev_rise && (ecnt[i] != 16'hFFFF)) ecnt[i] = ecnt[i] + 16'd1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("filt%0d", i), {15'd0, filt[i]}, {15'd0, lvl[i]});
         check($sformatf("rise%0d", i), {15'd0, rise[i]}, {15'd0, erise[i]});
         check($sformatf("fall%0d", i), {15'd0, fall[i]}, {15'd0, efall[i]});
         check($sformatf("evt%0d", i), evt[i], ecnt[i]);
      end
   endtask

   initial begin
      int lat;
      int nrise;
      int nhigh;
      int hold;
      rst_n = 1'b0;
      pad   = 1'b0;
      en    = 1'b1;
      clr   = 1'b0;
      repeat (3) tick();
      check("reset_filt", {15'd0, filt[0]}, 16'd0);
      check("reset_filt_hi", {15'd0, filt[1]}, 16'd1);
      rst_n = 1'b1;
      repeat (10) tick();

      // Clean rising edge: latency SYNC_STAGES + DEBOUNCE_CYCLES, single pulse.
      pad   = 1'b1;
      lat   = 0;
      nrise = 0;
      while ((filt[0] !== 1'b1) && (lat < 20)) begin
         tick();
         lat++;
         if (rise[0] === 1'b1) nrise++;
      end
      check("latency_rise", 16'(lat), 16'd6);
      repeat (4) begin
         tick();
         if (rise[0] === 1'b1) nrise++;
      end
      check("rise_pulses", 16'(nrise), 16'd1);
      check("evt_after_rise", evt[0], cnt_built ? 16'd1 : 16'd0);

      // Three-sample glitch is rejected.
      pad = 1'b0;
      repeat (12) tick();
      pad   = 1'b1;
      nhigh = 0;
      repeat (3) tick();
      pad = 1'b0;
      repeat (10) begin
         tick();
         if ((filt[0] === 1'b1) || (rise[0] === 1'b1)) nhigh++;
      end
      check("glitch_ignored", 16'(nhigh), 16'd0);

      // Disable mid-pending, then re-enable: a full debounce period is needed again.
      pad = 1'b1;
      repeat (4) tick();
      en = 1'b0;
      repeat (3) tick();
      check("hold_while_dis", {15'd0, filt[0]}, 16'd0);
      en  = 1'b1;
      lat = 0;
      while ((rise[0] !== 1'b1) && (lat < 20)) begin
         tick();
         lat++;
      end
      check("latency_reenable", 16'(lat), 16'd4);
      repeat (3) tick();

      // Reset during a pending fall discards it.
      pad = 1'b0;
      repeat (4) tick();
      check("pend_lo_held", {15'd0, filt[0]}, 16'd1);
      rst_n = 1'b0;
      tick();
      check("rst_pend_filt", {15'd0, filt[0]}, 16'd0);
      check("rst_pend_fall", {15'd0, fall[0]}, 16'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_filt", {15'd0, filt[0]}, 16'd0);
      check("post_rst_fall", {15'd0, fall[0]}, 16'd0);
      repeat (8) tick();

`ifdef PAD_INPUT_FILTER_EVT_CNT_EN
      // Saturation and clear-wins on a preloaded counter.
      force u_slow.evt_cnt_q = 16'hFFFF;
      @(negedge clk);
      release u_slow.evt_cnt_q;
      ecnt[0] = 16'hFFFF;
      pad = 1'b1;
      repeat (10) tick();
      check("evt_saturate", evt[0], 16'hFFFF);
      pad = 1'b0;
      repeat (10) tick();
      pad = 1'b1;
      lat = 0;
      while ((rise[0] !== 1'b1) && (lat < 20)) begin
         tick();
         lat++;
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("evt_clear_wins", evt[0], 16'd0);
      repeat (4) tick();
`endif

      // Random pad activity with occasional disable, clear and reset.
      for (int seg = 0; seg < 300; seg++) begin
         pad   = 1'($urandom_range(0, 1));
         en    = ($urandom_range(0, 9) != 0);
         clr   = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 59) != 0);
         hold  = $urandom_range(1, 8);
         repeat (hold) begin
            tick();
            rst_n = 1'b1;
            clr   = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pad_input_filter.md
PAD_INPUT_FILTER -- requirements
Module: pad_input_filter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable samples required to commit a level (legal range 1..65535).
REQ-003 The block SHALL have parameter RST_VAL, default 1'b0, filtered level after reset, matching the pad's pulldown default.
REQ-004 clk_i  input  1  single clock.
REQ-005 rst_ni  input  1  synchronous, active-low reset.
REQ-006 pad_i  input  1  asynchronous pad value, taken from the O pin of the input pad cell.
REQ-007 en_i  input  1  filter enable.
REQ-008 clr_i  input  1  event counter clear.
REQ-009 filt_o  output  1  debounced, synchronized level.
REQ-010 rise_o  output  1  one-cycle pulse on each committed 0->1 transition.
REQ-011 fall_o  output  1  one-cycle pulse on each committed 1->0 transition.
REQ-012 evt_cnt_o  output  16  count of committed rising transitions.

Function
REQ-013 pad_i SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the sampled value s.
REQ-014 The FSM SHALL have four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-015 STABLE_LO with s=1: if DEBOUNCE_CYCLES=1, go to STABLE_HI; otherwise go to PEND_HI and set cnt=1.
REQ-016 PEND_HI with s=0: go back to STABLE_LO and set cnt=0, with no pulse.
REQ-017 PEND_HI with s=1 and cnt=DEBOUNCE_CYCLES-1: go to STABLE_HI; otherwise with s=1, increment cnt.
REQ-018 STABLE_HI, PEND_LO and STABLE_LO transitions SHALL mirror REQ-015..017 with polarity inverted.
REQ-019 Registered outputs: filt_o=1 in STABLE_HI and PEND_LO; filt_o=0 in STABLE_LO and PEND_HI.
REQ-020 rise_o (fall_o) SHALL be high for exactly the one cycle after the edge entering STABLE_HI (STABLE_LO) from the opposite stable or pending state; it SHALL never be asserted on two consecutive cycles.
REQ-021 Latency from a clean pad change to filt_o change SHALL be SYNC_STAGES+DEBOUNCE_CYCLES cycles.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no filt_o change and no pulse.
REQ-023 cnt SHALL be 16 bits wide and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-024 en_i=0: PEND_HI forced to STABLE_LO and PEND_LO forced to STABLE_HI, cnt=0, filt_o held, no pulses; the synchronizer keeps sampling.
REQ-025 en_i rising: filtering SHALL resume from the held stable state on the next edge.
REQ-026 evt_cnt_o SHALL increment on each cycle where rise_o=1 and SHALL saturate at 16'hFFFF.
REQ-027 If clr_i=1 and rise_o=1 in the same cycle, clear SHALL win and evt_cnt_o SHALL become 0.

Reset
REQ-028 On a clock edge with rst_ni=0, all synchronizer flops SHALL load RST_VAL.
REQ-029 Reset SHALL set the state to STABLE_HI if RST_VAL=1, else STABLE_LO.
REQ-030 Reset SHALL set cnt=0, filt_o=RST_VAL, rise_o=0, fall_o=0 and evt_cnt_o=0.
REQ-031 Reset asserted mid-PEND SHALL discard the pending transition and emit no pulse.
REQ-032 A pad level differing from RST_VAL at reset release SHALL be treated as a normal transition after full latency.

Configuration
REQ-033 Macro PAD_INPUT_FILTER_EVT_CNT_EN defined: the event counter SHALL be implemented per REQ-026..027.
REQ-034 Macro PAD_INPUT_FILTER_EVT_CNT_EN undefined: no counter flops SHALL exist, evt_cnt_o SHALL be tied to 16'h0000, and clr_i SHALL be ignored.

Verification
REQ-035 SYNC_STAGES=2, DEBOUNCE_CYCLES=4: pad_i 0->1 held -> filt_o=1 exactly 6 cycles later, rise_o single pulse, evt_cnt_o=1.
REQ-036 Same config: 3-cycle high glitch on pad_i -> filt_o stays 0, no rise_o, evt_cnt_o unchanged.
REQ-037 en_i=0 while in PEND_HI after 2 samples, then en_i=1 with pad still high -> full 4 further samples needed before rise_o.
REQ-038 evt_cnt_o preloaded at 16'hFFFF via 65535 edges (or forced), one more rise -> stays 16'hFFFF; clr_i coincident with rise -> 0.
REQ-039 rst_ni=0 during PEND_LO with RST_VAL=0 -> filt_o=0, no fall_o, state STABLE_LO next cycle.
REQ-040 Build without PAD_INPUT_FILTER_EVT_CNT_EN: 10 rising events -> evt_cnt_o=0 throughout, filt_o/rise_o identical to the macro-enabled build.
